// File: rtl/pwm_capture.sv
// Multi-channel PWM period/high-time capture with a small register-mapped device bus.
// Each channel synchronizes its input, detects edges and times them with a per-channel FSM.

module pwm_capture_ch #(
  parameter int CtrWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pwm,
  input  logic                wr_status,
  input  logic                wr_ctrl,
  input  logic [1:0]          wdata,
  output logic                en,
  output logic                level,
  output logic                valid,
  output logic                ovf,
  output logic [CtrWidth-1:0] period,
  output logic [CtrWidth-1:0] high
);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE} state_e;

  state_e              state_q, state_d;
  logic [CtrWidth-1:0] cnt_q, cnt_d;
  logic                s1, s2, s3;
  logic                rise, fall, dis;
  logic                ld_period, ld_high, set_valid, set_ovf;

  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;
  assign level = s2;
  // A CTRL write clearing EN wins over any edge seen in the same cycle.
  assign dis   = wr_ctrl & ~wdata[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      s1      <= pwm;
      s2      <= s1;
      s3      <= s2;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_period = 1'b0;
    ld_high   = 1'b0;
    set_valid = 1'b0;
    set_ovf   = 1'b0;
    if (dis || !en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = WAIT_RISE;
        WAIT_RISE: begin
          if (rise) begin
            cnt_d   = CtrWidth'(1);
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            ld_period = 1'b1;
            set_valid = 1'b1;
            cnt_d     = CtrWidth'(1);
          end else if (cnt_q == '1) begin
            // Period too long to represent: abandon it and resync on the next rise.
            set_ovf = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_RISE;
          end else begin
            cnt_d   = cnt_q + CtrWidth'(1);
            ld_high = fall;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en     <= 1'b0;
      valid  <= 1'b0;
      ovf    <= 1'b0;
      period <= '0;
      high   <= '0;
    end else begin
      if (wr_ctrl)   en     <= wdata[0];
      if (ld_period) period <= cnt_q;
      if (ld_high)   high   <= cnt_q;
      if (set_valid)                   valid <= 1'b1;
      else if (wr_status && wdata[0])  valid <= 1'b0;
      if (set_ovf)                     ovf   <= 1'b1;
      else if (wr_status && wdata[1])  ovf   <= 1'b0;
    end
  end

endmodule

module pwm_capture #(
  parameter int NumChannels = 4,
  parameter int CtrWidth    = 16,
  parameter int BusWidth    = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   device_req_i,
  input  logic [BusWidth-1:0]    device_addr_i,
  input  logic                   device_we_i,
  input  logic [3:0]             device_be_i,
  input  logic [BusWidth-1:0]    device_wdata_i,
  output logic                   device_rvalid_o,
  output logic [BusWidth-1:0]    device_rdata_o,
  input  logic [NumChannels-1:0] pwm_i
);

  localparam int ChW = 6;

  logic [ChW-1:0]                        ch_sel;
  logic [1:0]                            reg_sel;
  logic [NumChannels-1:0]                wr_status, wr_ctrl, en, level, valid, ovf;
  logic [NumChannels-1:0][CtrWidth-1:0]  period, high;
  logic [BusWidth-1:0]                   rdata_d;
  logic                                  unused_bits;

  // 16-byte channel stride inside a 1 KiB window; byte lanes are not used.
  assign ch_sel      = device_addr_i[9:4];
  assign reg_sel     = device_addr_i[3:2];
  assign unused_bits = ^{device_be_i, device_addr_i[BusWidth-1:10], device_addr_i[1:0],
                         device_wdata_i[BusWidth-1:2]};

  always_comb begin
    wr_status = '0;
    wr_ctrl   = '0;
    for (int c = 0; c < NumChannels; c++) begin
      wr_status[c] = device_req_i & device_we_i & (ch_sel == ChW'(c)) & (reg_sel == 2'd2);
      wr_ctrl[c]   = device_req_i & device_we_i & (ch_sel == ChW'(c)) & (reg_sel == 2'd3);
    end
  end

  for (genvar g = 0; g < NumChannels; g++) begin : g_ch
    pwm_capture_ch #(.CtrWidth(CtrWidth)) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .pwm       (pwm_i[g]),
      .wr_status (wr_status[g]),
      .wr_ctrl   (wr_ctrl[g]),
      .wdata     (device_wdata_i[1:0]),
      .en        (en[g]),
      .level     (level[g]),
      .valid     (valid[g]),
      .ovf       (ovf[g]),
      .period    (period[g]),
      .high      (high[g])
    );
  end

  always_comb begin
    rdata_d = '0;
    if (device_req_i && !device_we_i) begin
      for (int c = 0; c < NumChannels; c++) begin
        if (ch_sel == ChW'(c)) begin
          unique case (reg_sel)
            2'd0: rdata_d = BusWidth'(period[c]);
            2'd1: rdata_d = BusWidth'(high[c]);
            2'd2: rdata_d = BusWidth'({level[c], ovf[c], valid[c]});
            2'd3: rdata_d = BusWidth'(en[c]);
            default: rdata_d = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      device_rvalid_o <= 1'b0;
      device_rdata_o  <= '0;
    end else begin
      device_rvalid_o <= device_req_i;
      device_rdata_o  <= rdata_d;
    end
  end

endmodule
